// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, load formats, FSM states.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } store_type_e;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b011,
    LD_HU = 3'b100
  } load_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10,
    DONE = 2'b11
  } lsu_state_e;

  localparam int TO_W = 8;

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it.
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  load_type,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = 8'(word >> {byte_off, 3'b000});
  assign lane_h = 16'(word >> {byte_off, 3'b000});

  always_comb begin
    case (load_type)
      LD_B:    result = {{24{lane_b[7]}}, lane_b};
      LD_H:    result = {{16{lane_h[15]}}, lane_h};
      LD_W:    result = word;
      LD_BU:   result = {24'h0, lane_b};
      LD_HU:   result = {16'h0, lane_h};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access stage: one valid/ready bus transaction per load/store,
// stalling the core until it completes, errors, or times out.
//
//   state | meaning
//   IDLE  | waiting for mem_read/mem_write; access checked here
//   REQ   | bus_valid held with stable fields until bus_ready
//   RESP  | read accepted, waiting for bus_rvalid
//   DONE  | one-cycle completion pulse, stall released
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [1:0]      store_type,
  input  logic [2:0]      load_type,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            err,
  output logic            bus_valid,
  input  logic            bus_ready,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_wstrb,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  lsu_state_e      state_q, state_d;
  logic            bus_valid_q, bus_valid_d;
  logic            bus_we_q, bus_we_d;
  logic [XLEN-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]      bus_wstrb_q, bus_wstrb_d;
  logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [2:0]      ld_q, ld_d;
  logic [1:0]      off_q, off_d;

  logic            req;
  logic            bad_type;
  logic            misalign;
  logic            chk_err;
  logic            timeout;
  store_type_e     acc_sz;
  logic [3:0]      strb;
  logic [XLEN-1:0] ld_ext;

  assign req     = mem_read | mem_write;
  assign timeout = (cnt_q == TO_LAST);

  // A simultaneous read+write is a write, so size comes from store_type then.
  always_comb begin
    acc_sz   = SZ_B;
    bad_type = 1'b0;
    if (mem_write) begin
      case (store_type)
        SZ_B:    acc_sz = SZ_B;
        SZ_H:    acc_sz = SZ_H;
        SZ_W:    acc_sz = SZ_W;
        default: bad_type = 1'b1;
      endcase
    end else begin
      case (load_type)
        LD_B, LD_BU: acc_sz = SZ_B;
        LD_H, LD_HU: acc_sz = SZ_H;
        LD_W:        acc_sz = SZ_W;
        default:     bad_type = 1'b1;
      endcase
    end
  end

  assign misalign = ((acc_sz == SZ_H) && addr[0]) || ((acc_sz == SZ_W) && (addr[1:0] != 2'b00));
  assign chk_err  = bad_type | misalign;

  always_comb begin
    case (acc_sz)
      SZ_B:    strb = 4'b0001 << addr[1:0];
      SZ_H:    strb = 4'b0011 << addr[1:0];
      default: strb = 4'b1111;
    endcase
  end

  load_extend u_load_extend (
    .load_type (ld_q),
    .byte_off  (off_q),
    .word      (bus_rdata),
    .result    (ld_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      ld_q        <= '0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      ld_q        <= ld_d;
      off_q       <= off_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = chk_err ? DONE : REQ;
      REQ: begin
        if (bus_ready)    state_d = bus_we_q ? DONE : RESP;
        else if (timeout) state_d = DONE;
      end
      RESP:    if (bus_rvalid || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus fields, captured result and the wait counter.
  always_comb begin
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    ld_d        = ld_q;
    off_d       = off_q;
    cnt_d       = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (chk_err) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            bus_valid_d = 1'b1;
            bus_we_d    = mem_write;
            bus_addr_d  = {addr[XLEN-1:2], 2'b00};
            bus_wstrb_d = strb;
            bus_wdata_d = wdata << {addr[1:0], 3'b000};
            ld_d        = load_type;
            off_d       = addr[1:0];
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_ready) begin
          bus_valid_d = 1'b0;
          cnt_d       = '0;
          if (bus_we_q) err_d = 1'b0;
        end else if (timeout) begin
          bus_valid_d = 1'b0;
          err_d       = 1'b1;
          rdata_d     = '0;
        end
      end
      RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_rvalid) begin
          rdata_d = ld_ext;
          err_d   = 1'b0;
        end else if (timeout) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    stall     = req & (state_q != DONE);
    done      = (state_q == DONE);
    rdata     = rdata_q;
    err       = err_q;
    bus_valid = bus_valid_q;
    bus_we    = bus_we_q;
    bus_addr  = bus_addr_q;
    bus_wstrb = bus_wstrb_q;
    bus_wdata = bus_wdata_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level reference memory model, bus responder, per-cycle compare.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  store_type = 2'b00;
  logic [2:0]  load_type = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall, done, err, bus_valid, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  int checks = 0;
  int failures = 0;

  load_store_unit #(.XLEN(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .store_type(store_type), .load_type(load_type), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata), .err(err),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk_err;
    bit          err;
    bit          we;
    logic [31:0] baddr;
    logic [3:0]  strb;
    logic [31:0] bwdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ref_b [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  int rdy_wait = 0;
  bit resp_on = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_b.exists(a) ? ref_b[a] : 8'h00;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    slv_mem[a] = v;
    for (int i = 0; i < 4; i++) ref_b[a + 32'(i)] = 8'(v >> (8 * i));
  endtask

  // Expected outcome from the ISA view: size in bytes, alignment by modulo, bytes from ref memory.
  function automatic exp_t model(input bit wr, input logic [1:0] st, input logic [2:0] lt,
                                 input logic [31:0] a, input logic [31:0] wd, input bit to);
    exp_t e;
    int sz, off;
    bit sgn;
    longint v;
    off = int'(a % 4);
    sz = 0;
    sgn = 1'b0;
    if (wr) begin
      case (st)
        2'd0: sz = 1;
        2'd1: sz = 2;
        2'd2: sz = 4;
        default: sz = 0;
      endcase
    end else begin
      case (lt)
        3'd0: begin sz = 1; sgn = 1'b1; end
        3'd1: begin sz = 2; sgn = 1'b1; end
        3'd2: sz = 4;
        3'd3: sz = 1;
        3'd4: sz = 2;
        default: sz = 0;
      endcase
    end
    if (sz == 0) e.chk_err = 1'b1;
    else         e.chk_err = (off % sz) != 0;
    e.err    = e.chk_err || to;
    e.we     = wr;
    e.baddr  = a - 32'(off);
    e.strb   = 4'(((1 << sz) - 1) << off);
    e.bwdata = wd << (8 * off);
    e.rdata  = 32'h0;
    if (!e.err && !wr) begin
      v = 0;
      for (int i = 0; i < sz; i++) v = v | (longint'(ref_rd(a + 32'(i))) << (8 * i));
      if (sgn && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
      e.rdata = 32'(v);
    end
    if (!e.err && wr)
      for (int i = 0; i < sz; i++) ref_b[a + 32'(i)] = 8'(wd >> (8 * i));
    return e;
  endfunction

  // Bus responder: ready after rdy_wait valid cycles, rvalid one cycle after a read handshake.
  logic        s_hs, s_we;
  logic [31:0] s_addr, s_wd, s_word;
  logic [3:0]  s_strb;
  int          vcnt = 0;
  always begin
    @(posedge clk);
    s_hs = rst_n && bus_valid && bus_ready;
    s_we = bus_we;
    s_addr = bus_addr;
    s_strb = bus_wstrb;
    s_wd = bus_wdata;
    #1;
    bus_rvalid = 1'b0;
    if (!rst_n) begin
      vcnt = 0;
      bus_ready = 1'b0;
    end else begin
      s_word = slv_mem.exists(s_addr) ? slv_mem[s_addr] : 32'h0;
      if (s_hs && s_we) begin
        for (int i = 0; i < 4; i++) if (s_strb[i]) s_word[8*i +: 8] = s_wd[8*i +: 8];
        slv_mem[s_addr] = s_word;
      end
      if (s_hs && !s_we && resp_on) begin
        bus_rvalid = 1'b1;
        bus_rdata = s_word;
      end
      if (bus_valid) vcnt++;
      else vcnt = 0;
      bus_ready = bus_valid && (vcnt > rdy_wait);
    end
  end

  // Per-cycle compare against the head of the expectation queue.
  exp_t ce;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_valid) begin
        if (exp_q.size() == 0 || exp_q[0].chk_err) begin
          checks++;
          failures++;
          $display("FAIL bus_valid_unexpected actual=1 required=0");
        end else begin
          chk("bus_addr", bus_addr, exp_q[0].baddr);
          chk("bus_we", 32'(bus_we), 32'(exp_q[0].we));
          chk("bus_wstrb", 32'(bus_wstrb), 32'(exp_q[0].strb));
          if (exp_q[0].we) chk("bus_wdata", bus_wdata, exp_q[0].bwdata);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected actual=1 required=0");
        end else begin
          ce = exp_q.pop_front();
          chk("err", 32'(err), 32'(ce.err));
          if (ce.err || !ce.we) chk("rdata", rdata, ce.rdata);
        end
      end
    end
  end

  int          vld_n;
  logic [31:0] last_rdata, f_addr, f_wdata;
  logic [3:0]  f_strb;
  logic        last_err, f_we;

  task automatic access(input string nm, input bit rd, input bit wr, input logic [1:0] st,
                        input logic [2:0] lt, input logic [31:0] a, input logic [31:0] wd,
                        input bit to, input int exp_stall);
    int n;
    bit got;
    exp_q.push_back(model(wr, st, lt, a, wd, to));
    mem_read = rd;
    mem_write = wr;
    store_type = st;
    load_type = lt;
    addr = a;
    wdata = wd;
    n = 0;
    got = 1'b0;
    vld_n = 0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      if (stall) n++;
      if (bus_valid) begin
        if (vld_n == 0) begin
          f_addr = bus_addr; f_strb = bus_wstrb; f_wdata = bus_wdata; f_we = bus_we;
        end
        vld_n++;
      end
      if (done) begin
        got = 1'b1;
        last_rdata = rdata;
        last_err = err;
      end
      @(posedge clk);
      #1;
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_no_done actual=no_done required=done", nm);
      exp_q.delete();
    end else begin
      chk({nm, "_stall"}, 32'(n), 32'(exp_stall));
    end
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_bus_valid"}, 32'(bus_valid), 32'h0);
    chk({nm, "_bus_we"}, 32'(bus_we), 32'h0);
    chk({nm, "_done"}, 32'(done), 32'h0);
    chk({nm, "_err"}, 32'(err), 32'h0);
    chk({nm, "_rdata"}, rdata, 32'h0);
    chk({nm, "_bus_addr"}, bus_addr, 32'h0);
    chk({nm, "_bus_wstrb"}, 32'(bus_wstrb), 32'h0);
    chk({nm, "_bus_wdata"}, bus_wdata, 32'h0);
  endtask

  initial begin
    preload(32'h0000_1000, 32'h0000_0000);
    preload(32'h0000_2000, 32'h80F1_7F3C);
    preload(32'h0000_3000, 32'h0102_0304);
    preload(32'h0000_5000, 32'h1122_3344);
    #3;
    chk_zero_outputs("reset");
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: byte store to top lane
    access("sb", 1'b0, 1'b1, 2'b00, 3'b000, 32'h0000_1003, 32'h0000_00A5, 1'b0, 2);
    chk("sb_bus_addr", f_addr, 32'h0000_1000);
    chk("sb_wstrb", 32'(f_strb), 32'h8);
    chk("sb_wdata", f_wdata, 32'hA500_0000);
    chk("sb_we", 32'(f_we), 32'h1);
    chk("sb_err", 32'(last_err), 32'h0);

    // 2: load formats
    access("lb", 1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_2002, 32'h0, 1'b0, 3);
    chk("lb_val", last_rdata, 32'hFFFF_FFF1);
    access("lbu", 1'b1, 1'b0, 2'b00, 3'b011, 32'h0000_2002, 32'h0, 1'b0, 3);
    chk("lbu_val", last_rdata, 32'h0000_00F1);
    access("lh", 1'b1, 1'b0, 2'b00, 3'b001, 32'h0000_2002, 32'h0, 1'b0, 3);
    chk("lh_val", last_rdata, 32'hFFFF_80F1);
    access("lhu", 1'b1, 1'b0, 2'b00, 3'b100, 32'h0000_2002, 32'h0, 1'b0, 3);
    chk("lhu_val", last_rdata, 32'h0000_80F1);
    access("lw", 1'b1, 1'b0, 2'b00, 3'b010, 32'h0000_2000, 32'h0, 1'b0, 3);
    chk("lw_val", last_rdata, 32'h80F1_7F3C);

    // 3: check errors, no bus activity
    access("lw_mis", 1'b1, 1'b0, 2'b00, 3'b010, 32'h0000_3001, 32'h0, 1'b0, 1);
    chk("lw_mis_err", 32'(last_err), 32'h1);
    chk("lw_mis_rdata", last_rdata, 32'h0);
    chk("lw_mis_vld", 32'(vld_n), 32'h0);
    access("sh_mis", 1'b0, 1'b1, 2'b01, 3'b000, 32'h0000_3003, 32'h0000_FFFF, 1'b0, 1);
    chk("sh_mis_err", 32'(last_err), 32'h1);
    chk("sh_mis_vld", 32'(vld_n), 32'h0);
    access("st_rsv", 1'b0, 1'b1, 2'b11, 3'b000, 32'h0000_3000, 32'h0000_0055, 1'b0, 1);
    chk("st_rsv_vld", 32'(vld_n), 32'h0);
    access("ld_rsv", 1'b1, 1'b0, 2'b00, 3'b101, 32'h0000_3000, 32'h0, 1'b0, 1);
    chk("ld_rsv_err", 32'(last_err), 32'h1);

    // read+write together is a write
    access("rw_sh", 1'b1, 1'b1, 2'b01, 3'b010, 32'h0000_3002, 32'h0000_BEEF, 1'b0, 2);
    chk("rw_sh_wdata", f_wdata, 32'hBEEF_0000);
    access("rw_lw", 1'b1, 1'b0, 2'b00, 3'b010, 32'h0000_3000, 32'h0, 1'b0, 3);
    chk("rw_lw_val", last_rdata, 32'hBEEF_0304);

    // 4: slow ready
    rdy_wait = 5;
    access("slow", 1'b1, 1'b0, 2'b00, 3'b100, 32'h0000_5002, 32'h0, 1'b0, 8);
    chk("slow_vld_cycles", 32'(vld_n), 32'h6);
    chk("slow_val", last_rdata, 32'h0000_1122);
    rdy_wait = 0;

    // 5: response timeout, then recovery
    resp_on = 1'b0;
    access("to_resp", 1'b1, 1'b0, 2'b00, 3'b010, 32'h0000_2000, 32'h0, 1'b1, 10);
    chk("to_resp_err", 32'(last_err), 32'h1);
    chk("to_resp_rdata", last_rdata, 32'h0);
    resp_on = 1'b1;
    access("after_to", 1'b1, 1'b0, 2'b00, 3'b010, 32'h0000_2000, 32'h0, 1'b0, 3);
    chk("after_to_val", last_rdata, 32'h80F1_7F3C);

    // request timeout: store must not land
    rdy_wait = 20;
    access("to_req", 1'b0, 1'b1, 2'b10, 3'b000, 32'h0000_6000, 32'hDEAD_BEEF, 1'b1, 9);
    chk("to_req_vld_cycles", 32'(vld_n), 32'h8);
    rdy_wait = 0;
    access("to_req_rb", 1'b1, 1'b0, 2'b00, 3'b010, 32'h0000_6000, 32'h0, 1'b0, 3);
    chk("to_req_rb_val", last_rdata, 32'h0);

    // 6: reset mid-REQ
    rdy_wait = 10;
    exp_q.push_back(model(1'b1, 2'b10, 3'b000, 32'h0000_4000, 32'h1234_5678, 1'b1));
    mem_write = 1'b1;
    store_type = 2'b10;
    addr = 32'h0000_4000;
    wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    chk("mid_req_valid", 32'(bus_valid), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk_zero_outputs("mid_rst");
    exp_q.delete();
    mem_write = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    rdy_wait = 0;
    @(posedge clk);
    #1;
    access("sw_post", 1'b0, 1'b1, 2'b10, 3'b000, 32'h0000_4000, 32'hCAFE_BABE, 1'b0, 2);
    access("lw_post", 1'b1, 1'b0, 2'b00, 3'b010, 32'h0000_4000, 32'h0, 1'b0, 3);
    chk("lw_post_val", last_rdata, 32'hCAFE_BABE);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
